// File: rtl/pipeline_ctrl.sv
// Hazard and pipeline-control unit for the five-stage core: load-use
// bubbles, branch squashes, syscall halt/resume and saturating
// performance counters.
//
// state   | meaning
// RUN     | normal operation, hazards resolved each cycle
// HALT    | pipeline frozen after a halting syscall, waiting for resume
// RELEASE | one cycle after resume; the syscall leaves EXE without re-halting
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             exe_is_load,
  input  logic [4:0]       exe_rd,
  input  logic             exe_branch_taken,
  input  logic             exe_syscall_halt,
  input  logic             resume,
  output logic             pc_go,
  output logic             if_id_go,
  output logic             if_id_clear,
  output logic             id_exe_go,
  output logic             id_exe_clear,
  output logic             exe_mem_go,
  output logic             mem_wb_go,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALT    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   resume_q;
  logic   resume_rise;
  logic   lu, br, sys;
  logic   sel_br, sel_lu;

  assign lu = exe_is_load && (exe_rd != 5'd0) &&
              ((id_uses_rs && (id_rs == exe_rd)) ||
               (id_uses_rt && (id_rt == exe_rd)));
  assign br = exe_branch_taken;
  // A syscall still sitting in EXE during RELEASE must not halt again.
  assign sys = exe_syscall_halt && (state == RUN);
  assign resume_rise = resume && !resume_q;

  // Priority selection outside HALT: sys beats br, br beats lu.
  assign sel_br = (state != HALT) && !sys && br;
  assign sel_lu = (state != HALT) && !sys && !br && lu;

  // State register and resume edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      resume_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      resume_q <= resume;
    end
  end

  // Next-state logic and go/clear generation.
  always_comb begin
    state_nxt    = state;
    pc_go        = 1'b1;
    if_id_go     = 1'b1;
    if_id_clear  = 1'b0;
    id_exe_go    = 1'b1;
    id_exe_clear = 1'b0;
    exe_mem_go   = 1'b1;
    mem_wb_go    = 1'b1;
    halted       = 1'b0;
    case (state)
      HALT: begin
        pc_go      = 1'b0;
        if_id_go   = 1'b0;
        id_exe_go  = 1'b0;
        exe_mem_go = 1'b0;
        mem_wb_go  = 1'b0;
        halted     = 1'b1;
        if (resume_rise) state_nxt = RELEASE;
      end
      default: begin
        if (state == RELEASE) state_nxt = RUN;
        else if (sys)         state_nxt = HALT;
        if (sys) begin
          pc_go      = 1'b0;
          if_id_go   = 1'b0;
          id_exe_go  = 1'b0;
          exe_mem_go = 1'b0;
          mem_wb_go  = 1'b0;
        end else if (br) begin
          if_id_clear  = 1'b1;
          id_exe_clear = 1'b1;
        end else if (lu) begin
          pc_go        = 1'b0;
          if_id_go     = 1'b0;
          id_exe_clear = 1'b1;
        end
      end
    endcase
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != HALT) && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 1'b1;
      if (sel_lu && (stall_cnt != '1))          stall_cnt <= stall_cnt + 1'b1;
      if (sel_br && (flush_cnt != '1))          flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and pipeline-control unit for the five-stage MIPS core. Drives the `go` (advance) and `clear` (flush-to-zero) inputs of the IF, IF_ID, ID_EXE, EXE_MEM and MEM_WB pipeline registers. Responsibilities:
- detects load-use hazards and branch redirects;
- freezes the whole pipeline on a halting syscall until the operator resume button is pressed;
- keeps saturating performance counters for the display.

## Interface

Parameters
- `CNT_W`, default 32: width of the performance counters.

Ports
- `clk`  in  1  : system clock; all state updates on the rising edge.
- `rst`  in  1  : asynchronous, active-high reset.
- `id_rs`  in  5  : rs field of the instruction in ID.
- `id_rt`  in  5  : rt field of the instruction in ID.
- `id_uses_rs`  in  1  : the ID instruction reads rs.
- `id_uses_rt`  in  1  : the ID instruction reads rt.
- `exe_is_load`  in  1  : the EXE instruction is a load (lw/lb/lh…).
- `exe_rd`  in  5  : destination register of the EXE instruction.
- `exe_branch_taken`  in  1  : branch or jump resolved taken in EXE.
- `exe_syscall_halt`  in  1  : the EXE instruction is a halting syscall.
- `resume`  in  1  : operator resume level; only a rising edge counts.
- `pc_go`  out  1  : PC register write enable.
- `if_id_go`  out  1  : IF_ID advance.
- `if_id_clear`  out  1  : IF_ID flush.
- `id_exe_go`  out  1  : ID_EXE advance.
- `id_exe_clear`  out  1  : ID_EXE flush.
- `exe_mem_go`  out  1  : EXE_MEM advance.
- `mem_wb_go`  out  1  : MEM_WB advance.
- `halted`  out  1  : the pipeline is frozen.
- `cycle_cnt`  out  CNT_W  : cycles spent outside HALT.
- `stall_cnt`  out  CNT_W  : load-use bubble cycles.
- `flush_cnt`  out  CNT_W  : branch-flush cycles.

## Operation

**State machine**: RUN, HALT, RELEASE. Reset state is RUN.
- RUN → HALT when `exe_syscall_halt` = 1.
- HALT → RELEASE on a rising edge of `resume`, detected against the registered `resume_q`.
- RELEASE → RUN unconditionally, after one cycle.

**Hazard terms** (combinational):
- `lu` = `exe_is_load` & (`exe_rd` != 0) & ((`id_uses_rs` & `id_rs` == `exe_rd`) | (`id_uses_rt` & `id_rt` == `exe_rd`)).
- `br` = `exe_branch_taken`.
- `sys` = `exe_syscall_halt` & (state == RUN). `exe_syscall_halt` is ignored in RELEASE, so the syscall leaves EXE without re-halting.

**Output priority** (combinational, evaluated in RUN or RELEASE):
1. `sys`: every go = 0 and every clear = 0. The syscall stays frozen in EXE. This also wins over a simultaneous `br` or `lu`.
2. `br`: every go = 1, `if_id_clear` = 1, `id_exe_clear` = 1. Both wrong-path instructions are squashed. Any `lu` is ignored, because the ID instruction is being squashed anyway.
3. `lu`: `pc_go` = 0, `if_id_go` = 0, `id_exe_go` = 1, `id_exe_clear` = 1 (one bubble). `exe_mem_go` = 1 and `mem_wb_go` = 1.
4. Otherwise: every go = 1 and every clear = 0.

**HALT state**: every go = 0, every clear = 0, and `halted` = 1. The hazard inputs are ignored.

**Counters**: increment on the clock edge and saturate at all-ones; there is no wrap.
- `cycle_cnt`: +1 on every cycle where the state is not HALT (including the `sys` cycle).
- `stall_cnt`: +1 on every cycle where rule 3 is selected.
- `flush_cnt`: +1 on every cycle where rule 2 is selected.

**Reset** (asynchronous):
- state = RUN, `resume_q` = 0, all counters = 0.
- Outputs then follow RUN with the current inputs; with idle inputs, every go = 1, every clear = 0, and `halted` = 0.
- A reset asserted while in HALT returns the state to RUN immediately.

## Timing

- Go/clear outputs are combinational from state and inputs, with zero-cycle latency. The pipeline registers sample them at the same edge.
- A load-use stall lasts exactly one cycle. At the next edge the load has moved to MEM, so `lu` drops naturally.
- Halt entry takes effect in the same cycle as `exe_syscall_halt`. `halted` rises after the next edge.
- Resume: rising edge of `resume` sampled at edge N. Then:
  - state = RELEASE in cycle N+1, with all go = 1 (subject to `br`/`lu`);
  - RUN from N+2.
- A `resume` already high at HALT entry does not release; it must go low and then high again.
- `resume` is assumed already synchronised to `clk`.

## Test plan

- **Reset**: assert `rst` mid-cycle with idle inputs → outputs immediately show every go = 1, every clear = 0, `halted` = 0, and all counters = 0, without waiting for `clk`.
- **Load-use**: `exe_is_load` = 1, `exe_rd` = 8, `id_rs` = 8, `id_uses_rs` = 1 → for one cycle, `pc_go` = 0, `if_id_go` = 0, `id_exe_clear` = 1; `stall_cnt` goes 0 → 1.
  - Same stimulus with `exe_rd` = 0 → no stall.
  - Same stimulus with `id_uses_rs` = 0 → no stall.
- **Branch over load-use**: `br` = 1 and `lu` = 1 together → `if_id_clear` = 1, `id_exe_clear` = 1, all go = 1; `flush_cnt` increments and `stall_cnt` is unchanged.
- **Halt and resume**:
  1. Pulse `exe_syscall_halt` with `br` = 1 → all go = 0, then `halted` = 1 and `cycle_cnt` frozen.
  2. Hold `exe_syscall_halt` high and pulse `resume` → one RELEASE cycle with all go = 1 and `halted` = 0, then RUN with no re-halt.
- **Resume edge rule**: `resume` held at 1 before and during HALT entry → the state remains HALT. Drop `resume` to 0, then raise it to 1 → release.
- **Saturation**: use `CNT_W` = 4 and run 20 idle cycles → `cycle_cnt` = 15 and stays at 15.
